dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width of both request ports and the memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have, for each port k in {0,1}, port reqk_valid, input, 1, requester k presents a request.
REQ-006 SHALL have reqk_ready, output, 1, request k accepted this cycle.
REQ-007 SHALL have reqk_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have reqk_addr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have reqk_wdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have rspk_valid, output, 1, one-cycle response pulse.
REQ-011 SHALL have rspk_rdata, output, DATA_WIDTH, read data.
REQ-012 SHALL have rspk_err, output, 1, misaligned-access flag.
REQ-013 SHALL have mem_we, output, 1, write strobe to the data memory.
REQ-014 SHALL have mem_addr, output, ADDR_WIDTH, byte address to the data memory.
REQ-015 SHALL have mem_wdata, output, DATA_WIDTH, write data to the data memory.
REQ-016 SHALL have mem_rdata, input, DATA_WIDTH, asynchronous read data from the data memory.

Function
REQ-017 SHALL grant at most one port per cycle; reqk_ready is combinational: reqk_ready = grant_k.
REQ-018 SHALL grant the single valid port when only one reqk_valid is high, irrespective of priority.
REQ-019 SHALL resolve simultaneous valids with a 1-bit priority pointer prio: grant port prio.
REQ-020 SHALL set prio to the other port on every clock edge with a grant; prio SHALL hold otherwise.
REQ-021 SHALL require requesters to hold valid/we/addr/wdata stable until ready; a dropped valid before ready is not an error and carries no state.
REQ-022 SHALL drive mem_addr/mem_wdata from the granted port, and drive them to 0 when there is no grant.
REQ-023 SHALL assert mem_we only when the granted request has we=1 and addr[1:0]==0.
REQ-024 SHALL, on acceptance, pulse rspk_valid high for exactly one cycle on the next cycle (latency 1) for reads and writes.
REQ-025 SHALL register rspk_rdata = mem_rdata sampled at acceptance for aligned reads, and 0 for writes and misaligned accesses.
REQ-026 SHALL accept misaligned requests (addr[1:0]!=0) without writing, and return rspk_err=1 alongside rspk_valid.
REQ-027 SHALL hold rspk_rdata and rspk_err until the next response for that port; rspk_valid is 0 in cycles with no response.
REQ-028 SHALL allow back-to-back acceptance on the same port every cycle (full throughput, no bubbles).
REQ-029 SHALL return the new value for a read accepted the cycle after a write to the same word, from either port.

Reset
REQ-030 SHALL, while rst=1, force reqk_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, and grant nothing.
REQ-031 SHALL reset prio=0, rspk_valid=0, rspk_rdata=0 and rspk_err=0.
REQ-032 SHALL drop any response pending when rst asserts; no rspk_valid pulse SHALL follow a reset.

Structure
REQ-033 SHALL place the default ADDR_WIDTH/DATA_WIDTH, NUM_PORTS=2 and a port-index typedef in the shared memory package.
REQ-034 SHALL implement arbitration in one sub-module, rr_arb2, which takes the valids and prio and outputs a one-hot grant and the next prio.
REQ-035 SHALL keep response registers and memory muxing in dmem_arbiter.

Verification
REQ-036 SHALL: port0 writes 0xDEADBEEF @0x0010 alone -> req0_ready same cycle, mem_we=1, rsp0_valid next cycle, rsp0_err=0.
REQ-037 SHALL: both ports read @0x0010 after reset -> port0 granted first, port1 granted next cycle; both rdata=0xDEADBEEF.
REQ-038 SHALL: both ports hold valid for 6 cycles -> grants alternate 0,1,0,1,0,1.
REQ-039 SHALL: port1 writes 0x12345678 @0x0020, then port0 reads 0x0020 next cycle -> rsp0_rdata=0x12345678.
REQ-040 SHALL: port0 writes @0x0013 -> mem_we=0, rsp0_valid=1 with rsp0_err=1, rdata=0, memory unchanged.
REQ-041 SHALL: rst asserted the cycle after an acceptance -> no rsp pulse, all outputs 0, prio=0 after release.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the default address/data widths, the number of requester ports,
// the port-index type and a small alignment helper used by the top level.
package dmem_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_PORTS      = 2;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

    // Word accesses are aligned when both low byte-address bits are zero.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-port round-robin arbiter (purely combinational).
// Ports:
//   valid_i     - request valids, one bit per port
//   prio_i      - current priority pointer (port favoured on a tie)
//   grant_o     - one-hot grant (all zero when nothing is valid)
//   prio_next_o - pointer to load on the next edge; points at the port
//                 that was NOT granted, so a tie alternates fairly
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid_i,
    input  port_idx_t            prio_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output port_idx_t            prio_next_o
);

    always_comb begin
        grant_o     = '0;
        prio_next_o = prio_i;

        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (prio_i == 1'b1) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase

        if (grant_o[0]) begin
            prio_next_o = 1'b1;
        end else if (grant_o[1]) begin
            prio_next_o = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: two requesters share one asynchronous-read memory.
// One request is accepted per cycle (round-robin on a tie); every accepted
// request gets a one-cycle response pulse on the following cycle.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   reqK_valid/we/addr/wdata  - request K (held stable until reqK_ready)
//   reqK_ready                - request K accepted this cycle
//   rspK_valid/rdata/err      - response K (rdata/err hold between pulses)
//   mem_we/addr/wdata         - memory write strobe, address, write data
//   mem_rdata                 - asynchronous memory read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [NUM_PORTS-1:0]  valid_gated;
    logic [NUM_PORTS-1:0]  grant;
    port_idx_t             prio_q, prio_d;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_aligned;

    logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [NUM_PORTS-1:0]  rsp_err_q,   rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rsp_rdata_d [NUM_PORTS];

    // Nothing may be granted while reset is held.
    assign valid_gated = {req1_valid, req0_valid} & {NUM_PORTS{~rst}};

    rr_arb2 u_arb (
        .valid_i     (valid_gated),
        .prio_i      (prio_q),
        .grant_o     (grant),
        .prio_next_o (prio_d)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Memory-side mux; all fields read as zero when no port is granted.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (grant[0]) begin
            sel_we    = req0_we;
            sel_addr  = req0_addr;
            sel_wdata = req0_wdata;
        end else if (grant[1]) begin
            sel_we    = req1_we;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    assign sel_aligned = is_aligned(sel_addr[1:0]);

    // Misaligned writes are accepted but never reach the memory.
    assign mem_we    = sel_we & sel_aligned;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;

    // Response capture: read data is sampled in the accepting cycle, so a read
    // that follows a write by one cycle sees the freshly written word.
    always_comb begin
        rsp_valid_d = grant;
        rsp_err_d   = rsp_err_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rsp_rdata_d[k] = rsp_rdata_q[k];
            if (grant[k]) begin
                rsp_err_d[k]   = ~sel_aligned;
                rsp_rdata_d[k] = (!sel_we && sel_aligned) ? mem_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                rsp_rdata_q[k] <= '0;
            end
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            for (int k = 0; k < NUM_PORTS; k++) begin
                rsp_rdata_q[k] <= rsp_rdata_d[k];
            end
        end
    end

    // Response outputs are masked during reset so a response pending when
    // reset rises is dropped in that very cycle.
    assign rsp0_valid = rsp_valid_q[0] & ~rst;
    assign rsp1_valid = rsp_valid_q[1] & ~rst;
    assign rsp0_err   = rsp_err_q[0] & ~rst;
    assign rsp1_err   = rsp_err_q[1] & ~rst;
    assign rsp0_rdata = rst ? '0 : rsp_rdata_q[0];
    assign rsp1_rdata = rst ? '0 : rsp_rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          v   [2];
    logic          we  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wd  [2];

    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_we(we[0]),
        .req0_addr(adr[0]), .req0_wdata(wd[0]),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_we(we[1]),
        .req1_addr(adr[1]), .req1_wdata(wd[1]),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Environment memory: asynchronous read, synchronous write.
    logic [DW-1:0] mem [0:(1<<(AW-2))-1];
    assign mem_rdata = mem[mem_addr[AW-1:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[AW-1:2]] <= mem_wdata;

    // Reference model state.
    int            total = 0;
    int            bad = 0;
    int            prio_m;
    int            last_g;
    bit            ev   [2];
    bit            eerr [2];
    logic [DW-1:0] erd  [2];
    logic [DW-1:0] shadow [int];

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] shadow_rd(input int idx);
        return shadow.exists(idx) ? shadow[idx] : '0;
    endfunction

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int  g;
        bit  al;
        int  idx;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (v[0] && v[1]) g = prio_m;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
        end
        chk("req0_ready", req0_ready, (g == 0));
        chk("req1_ready", req1_ready, (g == 1));
        chk("mem_we",    mem_we, (g >= 0) && we[g] && (adr[g][1:0] == 2'b00));
        chk("mem_addr",  mem_addr,  (g >= 0) ? adr[g] : '0);
        chk("mem_wdata", mem_wdata, (g >= 0) ? wd[g]  : '0);
        chk("rsp0_valid", rsp0_valid, rst ? 1'b0 : ev[0]);
        chk("rsp1_valid", rsp1_valid, rst ? 1'b0 : ev[1]);
        chk("rsp0_err",   rsp0_err,   rst ? 1'b0 : eerr[0]);
        chk("rsp1_err",   rsp1_err,   rst ? 1'b0 : eerr[1]);
        chk("rsp0_rdata", rsp0_rdata, rst ? '0 : erd[0]);
        chk("rsp1_rdata", rsp1_rdata, rst ? '0 : erd[1]);
        last_g = g;
        @(posedge clk);
        if (rst) begin
            prio_m = 0;
            for (int k = 0; k < 2; k++) begin
                ev[k] = 0; eerr[k] = 0; erd[k] = '0;
            end
        end else begin
            ev[0] = (g == 0);
            ev[1] = (g == 1);
            if (g >= 0) begin
                al  = (adr[g] % 4) == 0;
                idx = int'(adr[g]) / 4;
                eerr[g] = !al;
                erd[g]  = (!we[g] && al) ? shadow_rd(idx) : '0;
                if (we[g] && al) shadow[idx] = wd[g];
                prio_m = 1 - g;
            end
        end
        #1;
    endtask

    task automatic req(input int k, input logic vv, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        v[k] = vv; we[k] = w; adr[k] = a; wd[k] = d;
    endtask

    task automatic idle();
        req(0, 1'b0, 1'b0, '0, '0);
        req(1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1<<(AW-2)); i++) mem[i] = '0;
        prio_m = 0; last_g = -1;
        for (int k = 0; k < 2; k++) begin
            ev[k] = 0; eerr[k] = 0; erd[k] = '0;
        end
        rst = 1'b1;
        idle();
        #1;
        do_reset();
        cycle();

        // Lone write from port 0.
        req(0, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
        cycle();
        chk("wr_granted", last_g, 0);
        idle();
        cycle();
        chk("wr_rsp_err", rsp0_err, 1'b0);

        // Both read the same word after reset: port 0 first, then port 1.
        do_reset();
        req(0, 1'b1, 1'b0, 16'h0010, '0);
        req(1, 1'b1, 1'b0, 16'h0010, '0);
        cycle();
        chk("tie_first", last_g, 0);
        req(0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("tie_second", last_g, 1);
        chk("rd0_data", rsp0_rdata, 32'hDEADBEEF);
        idle();
        cycle();
        chk("rd1_data", rsp1_rdata, 32'hDEADBEEF);

        // Sustained contention alternates grants.
        do_reset();
        req(0, 1'b1, 1'b0, 16'h0010, '0);
        req(1, 1'b1, 1'b0, 16'h0014, '0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("alternate", last_g, i % 2);
        end
        idle();
        cycle();

        // Port 1 write followed next cycle by port 0 read of the same word.
        req(1, 1'b1, 1'b1, 16'h0020, 32'h12345678);
        cycle();
        idle();
        req(0, 1'b1, 1'b0, 16'h0020, '0);
        cycle();
        idle();
        cycle();
        chk("raw_data", rsp0_rdata, 32'h12345678);

        // Misaligned write: flagged, no memory update.
        req(0, 1'b1, 1'b1, 16'h0013, 32'hCAFEF00D);
        cycle();
        idle();
        cycle();
        chk("mis_err",   rsp0_err,   1'b1);
        chk("mis_rdata", rsp0_rdata, 32'h0);
        req(0, 1'b1, 1'b0, 16'h0010, '0);
        cycle();
        idle();
        cycle();
        chk("mis_unchanged", rsp0_rdata, 32'hDEADBEEF);

        // Reset right after an acceptance drops the pending response.
        req(0, 1'b1, 1'b0, 16'h0020, '0);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_no_pulse", rsp0_valid, 1'b0);
        req(0, 1'b1, 1'b0, 16'h0010, '0);
        req(1, 1'b1, 1'b0, 16'h0010, '0);
        cycle();
        chk("rst_prio", last_g, 0);
        idle();
        cycle();

        // Randomized traffic; requests are held until accepted.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(v[k] && last_g != k)) begin
                    logic [AW-1:0] a;
                    a = AW'($urandom_range(0, 15) * 4);
                    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                    req(k, ($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom);
                end
            end
            rst = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
